// File: rtl/cosim_pkg.sv
// Shared types and defaults for the cosim reset sequencing endpoints.
// Pure declarations; no logic, no latency, no flow control.
// State codes are visible on the debug port, so their values are fixed.
package cosim_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_HOLD  = 3'd1,
        ST_REQ   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } cosim_rst_state_e;

    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_REQ_TIMEOUT = 1024;
    localparam int DEF_CNT_W       = 32;

    // Width of a counter that spans 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cosim_rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts synchronously.
// Latency: release is seen on the 2nd posedge after rst_n rises.
// Backpressure: none.
module cosim_rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sync_rst_n <= 1'b0;
        end else begin
            meta_q     <= 1'b1;
            sync_rst_n <= meta_q;
        end
    end

endmodule

// File: rtl/cosim_reset_handshake.sv
// Sequenced core reset: sync release, hold, host handshake, then run-length count.
// Latency: core_rst falls 4 + HOLD_CYCLES posedges after rst_n rises if the host is ready.
// Backpressure: release_valid holds until release_ready; REQ_TIMEOUT stalled cycles -> FAULT.
module cosim_reset_handshake
    import cosim_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int REQ_TIMEOUT = DEF_REQ_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] run_cycles,
    output logic             release_valid,
    input  logic             release_ready,
    output logic             core_rst,
    output logic             run_done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int TW = cnt_width(REQ_TIMEOUT);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    REQ_LAST  = TW'(REQ_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync_rst_n;
    cosim_rst_state_e state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]    req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [CNT_W-1:0] cnt_d;

    cosim_rst_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (sync_rst_n)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        req_cnt_d  = req_cnt_q;
        run_len_d  = run_len_q;
        cnt_d      = cycle_count;
        case (state_q)
            ST_RESET: begin
                if (sync_rst_n) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = ST_REQ;
                    req_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_REQ: begin
                // A transfer on the final allowed cycle beats the timeout.
                if (release_valid && release_ready) begin
                    state_d   = ST_RUN;
                    run_len_d = run_cycles;
                    cnt_d     = '0;
                end else if (req_cnt_q == REQ_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    req_cnt_d = req_cnt_q + TW'(1);
                end
            end
            ST_RUN: begin
                if ((run_len_q != '0) && (cycle_count == run_len_q - CNT_ONE)) begin
                    state_d = ST_DONE;
                    cnt_d   = run_len_q;
                end else if (cycle_count != CNT_MAX) begin
                    cnt_d = cycle_count + CNT_ONE;
                end
            end
            ST_DONE, ST_FAULT: ;
            default: state_d = ST_RESET;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET;
            hold_cnt_q    <= '0;
            req_cnt_q     <= '0;
            run_len_q     <= '0;
            cycle_count   <= '0;
            core_rst      <= 1'b1;
            release_valid <= 1'b0;
            run_done      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            req_cnt_q     <= req_cnt_d;
            run_len_q     <= run_len_d;
            cycle_count   <= cnt_d;
            core_rst      <= !((state_d == ST_RUN) || (state_d == ST_DONE));
            release_valid <= (state_d == ST_REQ);
            run_done      <= (state_d == ST_DONE);
            timeout       <= (state_d == ST_FAULT);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cosim_reset_handshake.sv
// Directed bench: default instance (happy path, stall, run length, async reset),
// a short-timeout instance and a narrow-counter instance.
module tb_cosim_reset_handshake;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters
    logic        rst_a, ready_a, va, cra, da, toa;
    logic [31:0] run_a, cnta;
    logic [2:0]  sta;
    // Instance B: REQ_TIMEOUT = 16
    logic        rst_b, ready_b, vb, crb, db, tob;
    logic [31:0] run_b, cntb;
    logic [2:0]  stb;
    // Instance C: CNT_W = 4
    logic        rst_c, ready_c, vc, crc, dc, toc;
    logic [3:0]  run_c, cntc;
    logic [2:0]  stc;

    cosim_reset_handshake u_a (
        .clk(clk), .rst_n(rst_a), .run_cycles(run_a), .release_valid(va),
        .release_ready(ready_a), .core_rst(cra), .run_done(da), .timeout(toa),
        .cycle_count(cnta), .state(sta)
    );

    cosim_reset_handshake #(.REQ_TIMEOUT(16)) u_b (
        .clk(clk), .rst_n(rst_b), .run_cycles(run_b), .release_valid(vb),
        .release_ready(ready_b), .core_rst(crb), .run_done(db), .timeout(tob),
        .cycle_count(cntb), .state(stb)
    );

    cosim_reset_handshake #(.CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_c), .run_cycles(run_c), .release_valid(vc),
        .release_ready(ready_c), .core_rst(crc), .run_done(dc), .timeout(toc),
        .cycle_count(cntc), .state(stc)
    );

    // Expected state after posedge k+1 following an rst_n rise, host ready.
    int seq_st [8] = '{0, 0, 1, 1, 1, 1, 2, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Releases rst_a mid-cycle and checks the first n posedges of the sequence.
    task automatic release_a(input int n);
        rst_a = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            chk($sformatf("seq_state@%0d", k + 1), 32'(sta), seq_st[k]);
            chk($sformatf("seq_core_rst@%0d", k + 1), 32'(cra), (k == 7) ? 0 : 1);
            chk($sformatf("seq_valid@%0d", k + 1), 32'(va), (k == 6) ? 1 : 0);
        end
    endtask

    initial begin
        rst_a = 1'b0; ready_a = 1'b1; run_a = 32'd5;
        rst_b = 1'b0; ready_b = 1'b0; run_b = 32'd0;
        rst_c = 1'b0; ready_c = 1'b1; run_c = 4'd0;
        repeat (2) tick();

        chk("rst_state",    32'(sta), 0);
        chk("rst_core_rst", 32'(cra), 1);
        chk("rst_valid",    32'(va),  0);
        chk("rst_done",     32'(da),  0);
        chk("rst_timeout",  32'(toa), 0);
        chk("rst_count",    cnta,     0);
        chk("rst_b_core",   32'(crb), 1);
        chk("rst_c_core",   32'(crc), 1);

        // Happy path, then a 5-cycle run; run_cycles change mid-run is ignored
        release_a(8);
        chk("run_first_count", cnta, 0);
        tick();
        chk("run_count1", cnta, 1);
        run_a = 32'd99;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk($sformatf("run_count%0d", k), cnta, k);
            chk($sformatf("run_state%0d", k), 32'(sta), 3);
        end
        tick();
        chk("done_state", 32'(sta), 4);
        chk("done_flag",  32'(da),  1);
        chk("done_count", cnta,     5);
        chk("done_core",  32'(cra), 0);
        chk("done_valid", 32'(va),  0);
        repeat (3) tick();
        chk("done_hold_state", 32'(sta), 4);
        chk("done_hold_count", cnta,     5);
        chk("done_hold_flag",  32'(da),  1);

        // Asynchronous reset out of DONE, observed before any clock edge
        #2 rst_a = 1'b0;
        #1;
        chk("arst_done_flag",  32'(da),  0);
        chk("arst_done_count", cnta,     0);
        chk("arst_done_state", 32'(sta), 0);
        chk("arst_done_core",  32'(cra), 1);

        // Host stall: 10 REQ cycles with ready low, then release
        ready_a = 1'b0;
        run_a   = 32'd0;
        release_a(7);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("stall_valid%0d", i), 32'(va),  1);
            chk($sformatf("stall_state%0d", i), 32'(sta), 2);
            chk($sformatf("stall_to%0d", i),    32'(toa), 0);
        end
        ready_a = 1'b1;
        tick();
        chk("stall_run_state", 32'(sta), 3);
        chk("stall_run_count", cnta,     0);
        chk("stall_run_core",  32'(cra), 0);
        chk("stall_run_valid", 32'(va),  0);
        repeat (3) tick();
        chk("mid_run_count", cnta, 3);

        // Asynchronous reset mid-RUN, then a full re-release
        #3 rst_a = 1'b0;
        #1;
        chk("arst_run_core",  32'(cra), 1);
        chk("arst_run_count", cnta,     0);
        chk("arst_run_state", 32'(sta), 0);
        chk("arst_run_valid", 32'(va),  0);
        #1;
        release_a(8);
        chk("rerun_count", cnta, 0);

        // Timeout: REQ entered at posedge 7, 16 stalled cycles -> FAULT at 23
        rst_b = 1'b1;
        repeat (7) tick();
        chk("to_req_state", 32'(stb), 2);
        chk("to_req_valid", 32'(vb),  1);
        repeat (15) tick();
        chk("to_last_state", 32'(stb), 2);
        chk("to_last_flag",  32'(tob), 0);
        chk("to_last_valid", 32'(vb),  1);
        tick();
        chk("fault_state", 32'(stb), 5);
        chk("fault_flag",  32'(tob), 1);
        chk("fault_core",  32'(crb), 1);
        chk("fault_valid", 32'(vb),  0);
        ready_b = 1'b1;
        repeat (3) tick();
        chk("fault_late_state", 32'(stb), 5);
        chk("fault_late_core",  32'(crb), 1);
        chk("fault_late_flag",  32'(tob), 1);

        // Transfer on the final allowed REQ cycle wins over the timeout
        #2 rst_b = 1'b0;
        #1;
        chk("arst_fault_flag",  32'(tob), 0);
        chk("arst_fault_state", 32'(stb), 0);
        ready_b = 1'b0;
        #1 rst_b = 1'b1;
        repeat (22) tick();
        chk("edge_req_state", 32'(stb), 2);
        ready_b = 1'b1;
        tick();
        chk("edge_run_state", 32'(stb), 3);
        chk("edge_run_flag",  32'(tob), 0);
        chk("edge_run_core",  32'(crb), 0);

        // Unlimited run with a 4-bit counter saturates at 15
        rst_c = 1'b1;
        repeat (8) tick();
        chk("sat_run_state", 32'(stc), 3);
        chk("sat_run_count", 32'(cntc), 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_count%0d", k), 32'(cntc), (k < 15) ? k : 15);
            chk($sformatf("sat_done%0d", k),  32'(dc), 0);
        end
        chk("sat_end_state", 32'(stc), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
